// File: rtl/control_unit_if.sv
// Bus bundle between control_unit (master) and its instruction memory / datapath (slave).
interface control_unit_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_data;
   logic              data_req;
   logic              data_valid;
   logic              z;
   logic              load_en;
   logic [3:0]        a_sel;
   logic [3:0]        b_sel;
   logic [3:0]        dest_sel;
   logic [3:0]        op_sel;
   logic [15:0]       const_out;
   logic              const_sel;
   logic              data_sel;
   logic              halted;

   modport master (
      output imem_addr, data_req, load_en, a_sel, b_sel, dest_sel, op_sel,
             const_out, const_sel, data_sel, halted,
      input  imem_data, data_valid, z
   );

   modport slave (
      input  imem_addr, data_req, load_en, a_sel, b_sel, dest_sel, op_sel,
             const_out, const_sel, data_sel, halted,
      output imem_data, data_valid, z
   );
endinterface

// File: rtl/control_unit.sv
// Multi-word instruction fetch/decode/execute sequencer for a register-file datapath.
// Optional single-step mode (step port, PAUSE state) is enabled by defining CU_STEP_EN.
module control_unit #(
   parameter int ADDR_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef CU_STEP_EN
   input  logic                  step,
`endif
   control_unit_if.master        bus
);

   typedef enum logic [2:0] {
      S_F0, S_F1, S_F2, S_F3, S_EXEC, S_WAITD, S_HALT
`ifdef CU_STEP_EN
      , S_PAUSE
`endif
   } state_t;

   localparam logic [ADDR_W-1:0] PC_ONE = 1;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [15:0]       r_word0;
   logic [5:0]        r_ctl;
   logic [15:0]       r_const;
   logic [3:0]        r_op, r_dest, r_a, r_b;
   logic              r_const_sel, r_data_sel, r_wr_en, r_halt;
   logic [1:0]        r_br;
   logic              r_z;
`ifdef CU_STEP_EN
   logic              r_pause_halt;
`endif

   // Control word {const_sel, data_sel, wr_en, br[1:0], halt}: live in F2, latched afterwards.
   logic [5:0] w_ctl;
   logic       w_need_const;
   logic       w_enter_exec;
   logic       w_stall;
   logic       w_done;
   logic       w_zc;
   logic       w_take;

   assign w_ctl        = (r_state == S_F2) ? bus.imem_data[15:10] : r_ctl;
   assign w_need_const = w_ctl[5] | (w_ctl[2:1] != 2'b00);
   assign w_enter_exec = ((r_state == S_F2) & ~w_need_const) | (r_state == S_F3);
   assign w_stall      = (r_state == S_EXEC) & r_data_sel & ~bus.data_valid;
   assign w_done       = ((r_state == S_EXEC) & ~w_stall) |
                         ((r_state == S_WAITD) & bus.data_valid);
   // A stalled branch still resolves on the flag seen during EXEC, not a later one.
   assign w_zc         = (r_state == S_EXEC) ? bus.z : r_z;
   assign w_take       = (r_br == 2'b01) | ((r_br == 2'b10) & w_zc) | ((r_br == 2'b11) & ~w_zc);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_F0;
         r_pc        <= '0;
         r_word0     <= '0;
         r_ctl       <= '0;
         r_const     <= '0;
         r_op        <= '0;
         r_dest      <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_const_sel <= 1'b0;
         r_data_sel  <= 1'b0;
         r_wr_en     <= 1'b0;
         r_br        <= 2'b00;
         r_halt      <= 1'b0;
         r_z         <= 1'b0;
`ifdef CU_STEP_EN
         r_pause_halt <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_F0: begin
               r_pc    <= r_pc + PC_ONE;
               r_state <= S_F1;
            end
            S_F1: begin
               r_word0 <= bus.imem_data;
               r_pc    <= r_pc + PC_ONE;
               r_state <= S_F2;
            end
            S_F2: begin
               r_ctl <= bus.imem_data[15:10];
               if (w_need_const) begin
                  r_pc    <= r_pc + PC_ONE;
                  r_state <= S_F3;
               end else begin
                  r_state <= S_EXEC;
               end
            end
            S_F3: begin
               r_const <= bus.imem_data;
               r_state <= S_EXEC;
            end
            S_EXEC, S_WAITD: begin
               if (r_state == S_EXEC) r_z <= bus.z;
               if (w_stall) begin
                  r_state <= S_WAITD;
               end else if (w_done) begin
                  if (w_take) r_pc <= r_const[ADDR_W-1:0];
`ifdef CU_STEP_EN
                  r_pause_halt <= r_halt;
                  r_state      <= S_PAUSE;
`else
                  r_state <= r_halt ? S_HALT : S_F0;
`endif
               end
            end
`ifdef CU_STEP_EN
            S_PAUSE: begin
               if (step) r_state <= r_pause_halt ? S_HALT : S_F0;
            end
`endif
            S_HALT: r_state <= S_HALT;
            default: r_state <= S_F0;
         endcase

         // Decoded fields change only on entry to EXEC and hold until the next one.
         if (w_enter_exec) begin
            r_op        <= r_word0[15:12];
            r_dest      <= r_word0[11:8];
            r_a         <= r_word0[7:4];
            r_b         <= r_word0[3:0];
            r_const_sel <= w_ctl[5];
            r_data_sel  <= w_ctl[4];
            r_wr_en     <= w_ctl[3];
            r_br        <= w_ctl[2:1];
            r_halt      <= w_ctl[0];
         end
      end
   end

   assign bus.imem_addr = r_pc;
   assign bus.op_sel    = r_op;
   assign bus.dest_sel  = r_dest;
   assign bus.a_sel     = r_a;
   assign bus.b_sel     = r_b;
   assign bus.const_sel = r_const_sel;
   assign bus.data_sel  = r_data_sel;
   assign bus.const_out = r_const;
   assign bus.halted    = (r_state == S_HALT);
   // Strobes follow data_valid within the cycle; rst masks them so none escapes a reset cycle.
   assign bus.load_en   = ~rst & w_done & r_wr_en;
   assign bus.data_req  = ~rst & (w_stall | (r_state == S_WAITD));

endmodule
